// File: rtl/pixel_write_sink_pkg.sv
// Shared types and constants for the sprite pixel sink: screen geometry,
// framebuffer addressing, FIFO payload layout and sink state encoding.
package pixel_write_sink_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned FB_SIZE   = SCREEN_W * SCREEN_H;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned DROP_W    = 8;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // y*320 + x built from shifts: y*256 + y*64 + x
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
    return FB_ADDR_W'({y, 8'b0}) + FB_ADDR_W'({y, 6'b0}) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Pixel stream from the sprite drawers into the sink (valid/ready handshake).
interface pixel_write_sink_if
  import pixel_write_sink_pkg::*;
();

  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                writeEn;
  logic                ready;

  modport master (output x_in, output y_in, output colour_in, output writeEn, input ready);
  modport slave  (input x_in, input y_in, input colour_in, input writeEn, output ready);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with fall-through head; pointers wrap modulo DEPTH,
// the occupancy count carries one extra bit so full and empty are distinct.
module pixel_fifo
  import pixel_write_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  pixel_t                 din,
  input  logic                   pop,
  output pixel_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; occupancy tracking makes stale entries invisible
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Pixel sink: clips/filters incoming pixels, buffers them, commits them to the
// shared framebuffer write port, and runs the full-screen clear sequence.
module pixel_write_sink
  import pixel_write_sink_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH   = 8,
  parameter logic [COLOUR_W-1:0] TRANSPARENT  = 3'b000,
  parameter bit                  TRANSP_EN    = 1'b1,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_write_sink_if.slave    pix,
  input  logic                 clear_req,
  output logic                 clear_done,
  input  logic                 fb_busy,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOUR_W-1:0]  fb_data,
  output logic                 fb_we,
  output logic [DROP_W-1:0]    dropped_cnt,
  output logic                 idle
);

  localparam int unsigned          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_SIZE - 1);

  state_t               state;
  state_t               state_next;
  logic                 pending;
  logic [FB_ADDR_W-1:0] clr_addr;
  pixel_t               in_pix;
  pixel_t               head;
  logic                 accept;
  logic                 drop;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic                 fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_d;
  logic [COLOUR_W-1:0]  fb_data_d;
  logic                 clear_done_d;

  // Input side: ready depends on registers only, never on fb_busy
  assign pix.ready = !full && !pending && (state == ST_IDLE);
  assign accept    = pix.writeEn && pix.ready;
  assign drop      = (32'(pix.x_in) >= SCREEN_W) || (32'(pix.y_in) >= SCREEN_H) ||
                     (TRANSP_EN && (pix.colour_in == TRANSPARENT));
  assign push      = accept && !drop;
  assign in_pix    = '{x: pix.x_in, y: pix.y_in, colour: pix.colour_in};
  assign pop       = (state == ST_IDLE) && !empty && !fb_busy;
  assign idle      = (state == ST_IDLE) && (count == '0) && !pending;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_pix),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Clear starts only after every pixel queued ahead of the request has drained
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (pending && empty) state_next = ST_CLEAR;
      ST_CLEAR: if (!fb_busy && (clr_addr == CLR_LAST)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fb_we_d      = 1'b0;
    fb_addr_d    = '0;
    fb_data_d    = '0;
    clear_done_d = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pop) begin
          fb_we_d   = 1'b1;
          fb_addr_d = pixel_addr(head.x, head.y);
          fb_data_d = head.colour;
        end
      end
      ST_CLEAR: begin
        if (!fb_busy) begin
          fb_we_d      = 1'b1;
          fb_addr_d    = clr_addr;
          fb_data_d    = CLEAR_COLOUR;
          clear_done_d = (clr_addr == CLR_LAST);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_done <= 1'b0;
    end else begin
      fb_we      <= fb_we_d;
      fb_addr    <= fb_addr_d;
      fb_data    <= fb_data_d;
      clear_done <= clear_done_d;
    end
  end

  // Clear address only advances on cycles the port was actually ours
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (!fb_busy) clr_addr <= (clr_addr == CLR_LAST) ? '0 : clr_addr + FB_ADDR_W'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  // Pending spans request through DONE, so repeat requests in that window are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pending <= 1'b0;
    else if (state == ST_DONE)  pending <= 1'b0;
    else if (clear_req)         pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped_cnt <= '0;
    else if (accept && drop && (dropped_cnt != {DROP_W{1'b1}}))
      dropped_cnt <= dropped_cnt + DROP_W'(1);
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Randomized scoreboard bench for pixel_write_sink: a reference model predicts
// framebuffer writes from the pixel rules; a negedge monitor compares them.
module tb_pixel_write_sink;
  import pixel_write_sink_pkg::*;

  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0;
  logic        clear_done;
  logic        fb_busy = 1'b0;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic [7:0]  dropped_cnt;
  logic        idle;

  int unsigned checks = 0;
  int unsigned errors = 0;
  wr_t         exp_q[$];
  int unsigned drop_model = 0;
  bit          clear_armed = 1'b0;
  int unsigned done_seen = 0;
  bit          busy_last = 1'b0;

  pixel_write_sink_if pix ();

  pixel_write_sink dut (
    .clk         (clk),
    .reset       (reset),
    .pix         (pix),
    .clear_req   (clear_req),
    .clear_done  (clear_done),
    .fb_busy     (fb_busy),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .dropped_cnt (dropped_cnt),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference rules: clip to 320x240, drop colour 0, address y*320+x
  task automatic model_accept(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    wr_t w;
    if (x >= 9'd320 || y >= 8'd240 || c == 3'd0) begin
      if (drop_model < 255) drop_model++;
    end else begin
      w.addr = 17'(32'(y) * 320 + 32'(x));
      w.data = c;
      exp_q.push_back(w);
    end
  endtask

  task automatic cycle_pix(input logic v, input logic [8:0] x, input logic [7:0] y,
                           input logic [2:0] c, output bit acc);
    pix.writeEn   = v;
    pix.x_in      = x;
    pix.y_in      = y;
    pix.colour_in = c;
    acc = v && pix.ready;
    if (acc) model_accept(x, y, c);
    tick();
    pix.writeEn = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < max_cycles) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  // Monitor: every write must be expected, in order, and never follow a busy cycle
  always @(negedge clk) begin
    if (reset) begin
      busy_last = 1'b0;
    end else begin
      if (fb_we) begin
        wr_t w;
        checks++;
        if (busy_last) begin
          errors++;
          $display("FAIL write_after_busy: fb_we=1 addr %0d while port was busy", fb_addr);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", fb_addr, fb_data);
        end else begin
          w = exp_q.pop_front();
          if (fb_addr !== w.addr || fb_data !== w.data) begin
            errors++;
            $display("FAIL write_content: got addr %0d data %0d expected addr %0d data %0d",
                     fb_addr, fb_data, w.addr, w.data);
          end
        end
      end
      if (clear_done) begin
        checks++;
        if (!clear_armed || exp_q.size() != 0) begin
          errors++;
          $display("FAIL clear_done_pulse: armed %0d outstanding %0d expected armed 1 outstanding 0",
                   clear_armed, exp_q.size());
        end
        clear_armed = 1'b0;
        done_seen++;
      end
      busy_last = fb_busy;
    end
  end

  initial begin
    bit          acc;
    int unsigned sent;
    wr_t         w;

    pix.writeEn   = 1'b0;
    pix.x_in      = '0;
    pix.y_in      = '0;
    pix.colour_in = '0;
    repeat (3) tick();
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_ready", 32'(pix.ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst_dropped", 32'(dropped_cnt), 32'd0);
    check("post_rst_clear_done", 32'(clear_done), 32'd0);
    check("post_rst_fb_addr", 32'(fb_addr), 32'd0);

    // Single pixel latency: accepted at edge N, write visible after edge N+1
    cycle_pix(1'b1, 9'd10, 8'd5, 3'b100, acc);
    check("single_accept", 32'(acc), 32'd1);
    @(negedge clk);
    check("single_not_early", 32'(fb_we), 32'd0);
    @(negedge clk);
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_addr), 32'd1610);
    check("single_data", 32'(fb_data), 32'd4);
    wait_drain("single", 20);

    // Burst of 12 while the port is busy: only FIFO_DEPTH accepted, then drains in order
    fb_busy = 1'b1;
    tick();
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_pix(1'b1, 9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)),
                3'($urandom_range(1, 7)), acc);
      if (acc) sent++;
    end
    check("burst_accepted_while_busy", sent, 32'd8);
    check("burst_ready_full", 32'(pix.ready), 32'd0);
    fb_busy = 1'b0;
    for (int i = 0; i < 40 && sent < 12; i++) begin
      cycle_pix(1'b1, 9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)),
                3'($urandom_range(1, 7)), acc);
      if (acc) sent++;
    end
    check("burst_total", sent, 32'd12);
    wait_drain("burst", 40);

    // Clip and transparency boundaries plus legal corner pixels
    cycle_pix(1'b1, 9'd320, 8'd0, 3'd5, acc);
    cycle_pix(1'b1, 9'd0, 8'd240, 3'd2, acc);
    cycle_pix(1'b1, 9'd5, 8'd5, 3'd0, acc);
    cycle_pix(1'b1, 9'd319, 8'd239, 3'd7, acc);
    cycle_pix(1'b1, 9'd0, 8'd0, 3'd1, acc);
    wait_drain("clip", 20);
    check("clip_dropped", 32'(dropped_cnt), drop_model);
    check("clip_dropped_is_3", 32'(dropped_cnt), 32'd3);

    // Random traffic with random port contention
    for (int i = 0; i < 400; i++) begin
      fb_busy = ($urandom_range(0, 9) < 3);
      cycle_pix($urandom_range(0, 3) != 0, 9'($urandom_range(0, 383)),
                8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), acc);
    end
    fb_busy = 1'b0;
    wait_drain("random", 40);
    check("random_dropped", 32'(dropped_cnt), drop_model);

    // Clear with three pixels queued; the third arrives with the request itself
    fb_busy = 1'b1;
    tick();
    cycle_pix(1'b1, 9'd1, 8'd1, 3'd3, acc);
    cycle_pix(1'b1, 9'd2, 8'd2, 3'd6, acc);
    clear_req = 1'b1;
    cycle_pix(1'b1, 9'd3, 8'd3, 3'd2, acc);
    clear_req = 1'b0;
    check("clear_pixel_accepted", 32'(acc), 32'd1);
    check("clear_ready_drops", 32'(pix.ready), 32'd0);
    check("clear_not_idle", 32'(idle), 32'd0);
    for (int a = 0; a < 76800; a++) begin
      w.addr = 17'(a);
      w.data = 3'b000;
      exp_q.push_back(w);
    end
    clear_armed = 1'b1;
    for (int i = 0; i < 100000 && done_seen == 0; i++) begin
      fb_busy = ((i < 2000) || (i >= 74000 && i < 80000)) ? (i % 2 == 1) : 1'b0;
      clear_req = (i == 5000);
      tick();
    end
    fb_busy = 1'b0;
    clear_req = 1'b0;
    check("clear_done_seen", done_seen, 32'd1);
    check("clear_all_written", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check("clear_ready_back", 32'(pix.ready), 32'd1);
    check("clear_idle_back", 32'(idle), 32'd1);
    repeat (20) tick();
    check("clear_single_pulse", done_seen, 32'd1);

    // dropped_cnt saturates
    for (int i = 0; i < 300; i++) cycle_pix(1'b1, 9'd400, 8'd10, 3'd1, acc);
    tick();
    check("drop_saturates", 32'(dropped_cnt), 32'd255);
    check("drop_model_sat", 32'(dropped_cnt), drop_model);

    // Reset in the middle of a clear aborts everything at once
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int a = 0; a < 76800; a++) begin
      w.addr = 17'(a);
      w.data = 3'b000;
      exp_q.push_back(w);
    end
    clear_armed = 1'b1;
    repeat (100) tick();
    check("midclear_in_progress", 32'(idle), 32'd0);
    reset = 1'b1;
    #1;
    exp_q.delete();
    clear_armed = 1'b0;
    drop_model = 0;
    check("midclear_rst_fb_we", 32'(fb_we), 32'd0);
    check("midclear_rst_ready", 32'(pix.ready), 32'd1);
    check("midclear_rst_idle", 32'(idle), 32'd1);
    check("midclear_rst_dropped", 32'(dropped_cnt), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check("midclear_no_done", done_seen, 32'd1);
    check("midclear_idle_after", 32'(idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
